// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_txrx block: FSM state encodings,
// frame width and the default bit period.
package uart_pkg;
  localparam int DATA_BITS         = 8;
  localparam int CLKS_PER_BIT_DFLT = 434;  // 115200 baud from 50 MHz

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_DONE  = 3'd4
  } rx_state_e;
endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// A load of value L gives o_tc on the (L+1)-th cycle after the load edge.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART. Independent TX and RX engines, each with its own
// bit-period counter; RX samples mid-bit off a 2-flop synchronised line.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_byte_rdy,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  input  logic                 i_rx,
  output logic                 o_rx_byte_rdy,
  output logic [DATA_BITS-1:0] o_rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  // Entering START one edge after the line is seen low, so this lands on mid start bit.
  localparam logic [CW-1:0] HALF_LOAD = CW'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_e            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_data;
  logic [IW-1:0]        r_tx_idx;
  logic                 r_tx;
  logic                 w_tx_load;
  logic                 w_tx_tc;

  always_comb begin
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE:          w_tx_load = i_tx_byte_rdy;
      TX_START, TX_DATA: w_tx_load = w_tx_tc;
      default:          w_tx_load = 1'b0;
    endcase
  end

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tx_load),
    .i_load_val (BIT_LOAD),
    .o_tc       (w_tx_tc)
  );

  // r_tx_data shifts right so the next bit to send is always at [0].
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_data  <= '0;
      r_tx_idx   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (i_tx_byte_rdy) begin
          r_tx_data  <= i_tx_byte;
          r_tx_idx   <= '0;
          r_tx       <= 1'b0;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tc) begin
          r_tx       <= r_tx_data[0];
          r_tx_data  <= r_tx_data >> 1;
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tc) begin
          if (r_tx_idx == LAST_IDX) begin
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx      <= r_tx_data[0];
            r_tx_data <= r_tx_data >> 1;
            r_tx_idx  <= r_tx_idx + 1'b1;
          end
        end
        TX_STOP: if (w_tx_tc) r_tx_state <= TX_DONE;
        TX_DONE: r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = (r_tx_state == TX_START) || (r_tx_state == TX_DATA) ||
                     (r_tx_state == TX_STOP);
  assign o_tx_done = (r_tx_state == TX_DONE);

  // ---------------- RX ----------------
  rx_state_e            r_rx_state;
  logic [1:0]           r_rx_sync;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DATA_BITS-1:0] r_rx_byte;
  logic [IW-1:0]        r_rx_idx;
  logic                 w_rx;
  logic                 w_rx_load;
  logic                 w_rx_tc;
  logic [CW-1:0]        w_rx_load_val;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rx_sync <= 2'b11;
    else       r_rx_sync <= {r_rx_sync[0], i_rx};
  end
  assign w_rx = r_rx_sync[1];

  always_comb begin
    w_rx_load = 1'b0;
    case (r_rx_state)
      RX_IDLE:  w_rx_load = ~w_rx;
      RX_START: w_rx_load = w_rx_tc & ~w_rx;
      RX_DATA:  w_rx_load = w_rx_tc;
      default:  w_rx_load = 1'b0;
    endcase
  end
  assign w_rx_load_val = (r_rx_state == RX_IDLE) ? HALF_LOAD : BIT_LOAD;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .o_tc       (w_rx_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_idx   <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (!w_rx) r_rx_state <= RX_START;
        RX_START: if (w_rx_tc) begin
          r_rx_idx   <= '0;
          r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_rx_tc) begin
          r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == LAST_IDX) r_rx_state <= RX_STOP;
          else                      r_rx_idx   <= r_rx_idx + 1'b1;
        end
        // A low stop bit drops the byte; the output register keeps its old value.
        RX_STOP: if (w_rx_tc) begin
          if (w_rx) begin
            r_rx_byte  <= r_rx_shift;
            r_rx_state <= RX_DONE;
          end else begin
            r_rx_state <= RX_IDLE;
          end
        end
        RX_DONE: r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_byte     = r_rx_byte;
  assign o_rx_byte_rdy = (r_rx_state == RX_DONE);
endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: TX waveform, RX decode, loopback, glitch,
// framing error and mid-frame reset.
module tb_uart_txrx;
  localparam int N = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_rdy = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx, tx_busy, tx_done;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_in;
  logic       rx_rdy;
  logic [7:0] rx_byte;

  assign rx_in = loop ? tx : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(N)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tx_byte_rdy (tx_rdy),
    .i_tx_byte     (tx_byte),
    .o_tx          (tx),
    .o_tx_busy     (tx_busy),
    .o_tx_done     (tx_done),
    .i_rx          (rx_in),
    .o_rx_byte_rdy (rx_rdy),
    .o_rx_byte     (rx_byte)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;
  int rdy_cyc = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (rx_rdy) begin
      rdy_cnt <= rdy_cnt + 1;
      rdy_cyc <= cyc;
      rx_q.push_back(rx_byte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives a full 8N1 frame starting at the current negedge; returns at the
  // negedge where the stop bit ends, with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (N) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    tx_byte = b;
    tx_rdy  = 1'b1;
    @(negedge clk);
    tx_rdy  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int t = 0; t < 11 * N && !tx_done; t++) @(negedge clk);
    chk(tag, tx_done, 1'b1);
  endtask

  logic [9:0] frame_ab;
  int         bit_err[10];
  int         busy_err, idle_err, dcyc, d0, r0, f0;
  logic [7:0] lb[4];
  logic [31:0] got;

  initial begin
    frame_ab = 10'b1101010110;  // 0xAB: start, 1,1,0,1,0,1,0,1, stop
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'hA5;
    for (int k = 0; k < 10; k++) bit_err[k] = 0;
    busy_err = 0; idle_err = 0; dcyc = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_rdy", rx_rdy, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    repeat (5) @(negedge clk);

    // TX 0xAB, with an ignored request and a byte change while busy
    d0 = done_cnt;
    pulse_tx(8'hAB);
    for (int c = 1; c <= 10 * N + 20; c++) begin
      if (c <= 10 * N) begin
        if (tx !== frame_ab[(c - 1) / N]) bit_err[(c - 1) / N]++;
        if (tx_busy !== 1'b1) busy_err++;
      end else if (tx !== 1'b1 || tx_busy !== 1'b0) begin
        idle_err++;
      end
      if (tx_done) dcyc = c;
      if (c == 1000) begin tx_byte = 8'h00; tx_rdy = 1'b1; end
      else tx_rdy = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) chk($sformatf("tx_ab_bit%0d", k), bit_err[k], 0);
    chk("tx_ab_busy", busy_err, 0);
    chk("tx_ab_idle_after", idle_err, 0);
    chk("tx_ab_done_cnt", done_cnt - d0, 1);
    chk("tx_ab_done_cyc", dcyc, 10 * N + 1);

    // RX 0x3F
    r0 = rdy_cnt;
    f0 = cyc;
    send_frame(8'h3F, 1'b1);
    @(negedge clk);
    chk("rx_3f_byte", rx_byte, 8'h3F);
    chk("rx_3f_rdy_cnt", rdy_cnt - r0, 1);
    chk("rx_3f_latency", (rdy_cyc - f0 >= 4120) && (rdy_cyc - f0 <= 4130), 1'b1);

    // Loopback back-to-back
    loop = 1'b1;
    rx_q.delete();
    r0 = rdy_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse_tx(lb[i]);
      wait_done($sformatf("lb_done%0d", i));
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("lb_rdy_cnt", rdy_cnt - r0, 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
      chk($sformatf("lb_byte%0d", i), got, {24'h0, lb[i]});
    end
    loop = 1'b0;
    repeat (10) @(negedge clk);

    // Short low glitch on an idle line
    r0 = rdy_cnt;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_no_rdy", rdy_cnt - r0, 0);

    // Framing error: 0x12 with a low stop bit
    send_frame(8'h12, 1'b0);
    repeat (N) @(negedge clk);
    chk("frame_err_no_rdy", rdy_cnt - r0, 0);
    chk("frame_err_hold", rx_byte, 8'hA5);

    // Reset during TX bit 3 and RX bit 4
    r0 = rdy_cnt;
    d0 = done_cnt;
    fork
      send_frame(8'hE7, 1'b1);
      begin
        repeat (N) @(negedge clk);
        pulse_tx(8'h96);
        repeat (4 * N + 299) @(negedge clk);
        chk("pre_rst_tx_low", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", tx_busy, 1'b0);
        chk("rst_mid_rx_byte", rx_byte, 8'h00);
        rst = 1'b0;
      end
    join
    repeat (2 * N) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_rdy", rdy_cnt - r0, 0);

    // Recovery: 0xC3 round trip
    loop = 1'b1;
    rx_q.delete();
    r0 = rdy_cnt;
    pulse_tx(8'hC3);
    wait_done("post_rst_done");
    repeat (20) @(negedge clk);
    chk("post_rst_rdy_cnt", rdy_cnt - r0, 1);
    got = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hDEAD;
    chk("post_rst_byte", got, 32'hC3);
    chk("post_rst_rx_byte", rx_byte, 8'hC3);
    loop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: one transmit engine and one receive engine, independent, sharing one clock and one bit-rate parameter.
- 8N1 frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Sits between the system fabric (byte-wide strobe interface) and the board serial pins.
- Default bit rate is 115200 baud from a 50 MHz clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit. Legal range is 4 or more. Counter width is $clog2(CLKS_PER_BIT).

Ports:
- i_clk  input  1  system clock, all logic on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_tx_byte_rdy  input  1  one-cycle request to transmit i_tx_byte
- i_tx_byte  input  8  byte to transmit, sampled when the request is accepted
- o_tx  output  1  serial transmit line, idles high
- o_tx_busy  output  1  high while a frame is in progress
- o_tx_done  output  1  one-cycle pulse at the end of the stop bit
- i_rx  input  1  asynchronous serial receive line, idles high
- o_rx_byte_rdy  output  1  one-cycle pulse when a valid byte is received
- o_rx_byte  output  8  last valid received byte, held until the next valid byte

Behaviour:
- Reset values: o_tx=1, o_tx_busy=0, o_tx_done=0, o_rx_byte_rdy=0, o_rx_byte=0x00. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame. o_tx is high on the cycle after i_rst is sampled. No done or rdy pulse is produced for the aborted frame.
- TX FSM states: IDLE, START, DATA, STOP, DONE.
- TX IDLE: o_tx=1, busy=0. If i_tx_byte_rdy=1, latch i_tx_byte, go to START, set busy=1.
- TX timing: o_tx falls on the cycle after acceptance.
- TX START/DATA/STOP: each bit is held exactly CLKS_PER_BIT cycles. DATA sends bit index 0..7 in order.
- TX DONE: one cycle. o_tx_done=1, o_tx=1, busy=0. Then return to IDLE.
- TX request handling: a new request is accepted from the cycle after DONE. i_tx_byte_rdy is ignored when not in IDLE (no queueing). Changes to i_tx_byte after acceptance have no effect.
- TX total: request to done pulse is 10*CLKS_PER_BIT+1 cycles.
- RX input: i_rx passes through a 2-flop synchronizer. All decisions use the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP, DONE.
- RX IDLE: a low level on the synchronized line moves the FSM to START.
- RX START: wait (CLKS_PER_BIT-1)/2 cycles to reach mid-bit, then sample. If low, go to DATA. If high, treat it as a glitch and return to IDLE with no output.
- RX DATA: sample every CLKS_PER_BIT cycles, filling bits 0..7 LSB first into a shift register.
- RX STOP: sample one CLKS_PER_BIT later.
  - If the sample is 1, go to DONE.
  - If the sample is 0 (framing error), discard the byte, leave o_rx_byte unchanged, pulse nothing, and return to IDLE.
- RX DONE: one cycle. o_rx_byte is loaded and o_rx_byte_rdy=1 in the same cycle. Then return to IDLE.
- RX line held low continuously: produces repeated framing errors and no output.
- TX and RX run fully concurrently with no interaction. Loopback (o_tx wired to i_rx) must round-trip any byte.
- Tolerance: RX must accept frames with up to ±2% bit-rate error.

Decomposition:
- Package uart_pkg holds:
  - TX and RX state enums.
  - Constants DATA_BITS=8 and the default CLKS_PER_BIT=434.
- One sub-module, uart_baud_counter:
  - Loadable down-counter with a terminal-count strobe, parameterised by CLKS_PER_BIT.
  - Instantiated once in the TX path and once in the RX path.
- The FSMs stay in the top module. Target size is roughly 200 lines of RTL.

Test Plan:
- TX 0xAB:
  - Pulse i_tx_byte_rdy for one cycle. o_tx must carry 0,1,1,0,1,0,1,0,1,1, each bit 434 cycles.
  - busy is high throughout. o_tx_done pulses once at cycle 4341 after the request.
  - A second request issued while busy is ignored.
- RX 0x3F:
  - Drive i_rx with a correct 8N1 frame. o_rx_byte must be 0x3F with a single o_rx_byte_rdy pulse about 9.5 bit periods (plus 2 sync cycles) after the falling edge.
  - Also check o_rx_byte==0x3F one clock after the stop bit ends.
- Loopback:
  - Connect o_tx to i_rx and send 0x00, 0xFF, 0x55, 0xA5 back-to-back. Each must be received intact with exactly four rdy pulses.
- Glitch and framing error:
  - Low pulse of 100 cycles on idle i_rx: no rdy, and RX returns to IDLE.
  - Frame 0x12 with stop bit 0: no rdy, o_rx_byte keeps its previous value.
- Reset mid-frame:
  - Assert i_rst during TX bit 3 and RX bit 4. o_tx is high next cycle and no done/rdy pulse follows.
  - A subsequent 0xC3 transmit and receive both succeed.
